// File: rtl/match_reporter.sv
// match_reporter: snapshots sticky engine match bits a fixed delay after end of packet,
// then serialises the set bits lowest-first into (rule id, last) records through a FIFO.
module match_reporter #(
    parameter int NUM_ENGINES = 32,
    parameter int ID_W        = 5,
    parameter int FIFO_DEPTH  = 8,
    parameter int EOD_LAT     = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   en,
    input  logic                   sod,
    input  logic                   eod,
    input  logic [NUM_ENGINES-1:0] eng_match,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [ID_W-1:0]        rpt_id,
    output logic                   rpt_last,
    output logic [31:0]            pkt_cnt,
    output logic [31:0]            match_cnt,
    output logic [15:0]            drop_cnt
);

    localparam int TW = (EOD_LAT > 1) ? $clog2(EOD_LAT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [NUM_ENGINES-1:0] VEC_ONE = NUM_ENGINES'(1);
    localparam logic [AW:0]            PTR_ONE = (AW + 1)'(1);
    localparam logic [TW-1:0]          TMR_ONE = TW'(1);
    localparam logic [TW-1:0]          TMR_INIT = TW'(EOD_LAT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, RELOAD} state_t;

    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_ENGINES-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    state_t                 state_q, state_d;
    logic                   tmr_act_q, tmr_act_d;
    logic [TW-1:0]          tmr_cnt_q, tmr_cnt_d;
    logic [NUM_ENGINES-1:0] scan_q, scan_d;
    logic [NUM_ENGINES-1:0] pend_q, pend_d;
    logic [AW:0]            wr_q, rd_q;
    logic [ID_W:0]          mem_q [FIFO_DEPTH];
    logic [31:0]            pkt_cnt_q, match_cnt_q;
    logic [15:0]            drop_cnt_q;

    logic                   snap_fire, snap_nz, abort, snap_drop;
    logic                   push, pop, fifo_full, fifo_can_push;
    logic [ID_W-1:0]        push_id;
    logic                   push_last;
    logic [NUM_ENGINES-1:0] scan_clr;
    logic [ID_W:0]          rd_word;

    // The engines share the byte strobe, but capture timing is purely eod-driven.
    logic unused_en;
    assign unused_en = en;

    assign fifo_full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rpt_valid     = (wr_q != rd_q);
    assign pop           = rpt_valid && rpt_ready;
    assign fifo_can_push = !fifo_full || pop;
    assign rd_word       = mem_q[rd_q[AW-1:0]];
    assign rpt_id        = rpt_valid ? rd_word[ID_W-1:0] : '0;
    assign rpt_last      = rpt_valid ? rd_word[ID_W] : 1'b0;

    assign scan_clr  = scan_q & (scan_q - VEC_ONE);
    assign push_id   = lowest_set(scan_q);
    assign push_last = (scan_clr == '0);

    // Capture timer: a sod while armed aborts; a new eod always re-arms.
    always_comb begin
        tmr_act_d = tmr_act_q;
        tmr_cnt_d = tmr_cnt_q;
        snap_fire = 1'b0;
        abort     = 1'b0;
        if (tmr_act_q) begin
            if (sod) begin
                abort     = 1'b1;
                tmr_act_d = 1'b0;
            end else if (tmr_cnt_q == '0) begin
                snap_fire = 1'b1;
                tmr_act_d = 1'b0;
            end else begin
                tmr_cnt_d = tmr_cnt_q - TMR_ONE;
            end
        end
        if (eod) begin
            tmr_act_d = 1'b1;
            tmr_cnt_d = TMR_INIT;
        end
    end

    assign snap_nz = snap_fire && (eng_match != '0);

    always_comb begin
        state_d   = state_q;
        scan_d    = scan_q;
        pend_d    = pend_q;
        push      = 1'b0;
        snap_drop = 1'b0;
        case (state_q)
            IDLE: begin
                // Pending can only be occupied here by a snapshot taken during RELOAD.
                if (pend_q != '0) begin
                    scan_d  = pend_q;
                    pend_d  = snap_nz ? eng_match : '0;
                    state_d = SCAN;
                end else if (snap_nz) begin
                    scan_d  = eng_match;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (fifo_can_push) begin
                    push   = 1'b1;
                    scan_d = scan_clr;
                    if (push_last) state_d = RELOAD;
                end
                if (snap_nz) begin
                    if (pend_q == '0) pend_d = eng_match;
                    else              snap_drop = 1'b1;
                end
            end
            RELOAD: begin
                if (pend_q != '0) begin
                    scan_d  = pend_q;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
                pend_d = snap_nz ? eng_match : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            tmr_act_q   <= 1'b0;
            tmr_cnt_q   <= '0;
            scan_q      <= '0;
            pend_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            pkt_cnt_q   <= '0;
            match_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            tmr_act_q <= tmr_act_d;
            tmr_cnt_q <= tmr_cnt_d;
            scan_q    <= scan_d;
            pend_q    <= pend_d;
            if (push) wr_q <= wr_q + PTR_ONE;
            if (pop)  rd_q <= rd_q + PTR_ONE;
            if (snap_fire) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (push)      match_cnt_q <= match_cnt_q + 32'd1;
            if ((abort || snap_drop) && (drop_cnt_q != 16'hFFFF))
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {push_last, push_id};
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign match_cnt = match_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_match_reporter.sv
// Bench for match_reporter: directed packets checked against a transaction-level
// model of snapshot timing, aborts, planned drops and record order.
module tb_match_reporter;
    localparam int NE = 32;
    localparam int IW = 5;
    localparam int FD = 8;
    localparam int EL = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          en = 1'b0;
    logic          sod = 1'b0;
    logic          eod = 1'b0;
    logic          rpt_ready = 1'b0;
    logic [NE-1:0] eng_match = '0;
    logic          rpt_valid, rpt_last;
    logic [IW-1:0] rpt_id;
    logic [31:0]   pkt_cnt, match_cnt;
    logic [15:0]   drop_cnt;

    match_reporter #(.NUM_ENGINES(NE), .ID_W(IW), .FIFO_DEPTH(FD), .EOD_LAT(EL)) dut (
        .clk(clk), .resetn(resetn), .en(en), .sod(sod), .eod(eod),
        .eng_match(eng_match), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_id(rpt_id), .rpt_last(rpt_last), .pkt_cnt(pkt_cnt),
        .match_cnt(match_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [IW-1:0] id; logic last; } rec_t;

    rec_t   exp_q[$];
    rec_t   log_q[$];
    int     n_tests = 0;
    int     n_fail = 0;
    int     m_pkt = 0, m_match = 0, m_drop = 0;
    longint cyc = 0;
    longint due = -1;
    int     snap_seq = 0;
    int     drop_at = -1;

    function automatic void chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction

    // Model: a packet's snapshot is due EL edges after its eod unless a sod lands first.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_q.delete();
            m_pkt = 0; m_match = 0; m_drop = 0; due = -1;
        end else begin
            cyc++;
            if (due >= 0 && sod) begin
                due = -1;
                m_drop++;
            end else if (due == cyc) begin
                due = -1;
                m_pkt++;
                if (eng_match != '0) begin
                    if (snap_seq == drop_at) m_drop++;
                    else begin
                        for (int i = 0; i < NE; i++) begin
                            if (eng_match[i]) begin
                                exp_q.push_back('{id: IW'(i), last: ((eng_match >> (i + 1)) == '0)});
                                m_match++;
                            end
                        end
                    end
                    snap_seq++;
                end
            end
            if (eod) due = cyc + EL;
        end
    end

    logic [IW:0] held = '0;
    bit          stalled = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            chk("reset_valid", longint'(rpt_valid), 0);
            chk("reset_rec", longint'({rpt_id, rpt_last}), 0);
            chk("reset_counters", longint'(pkt_cnt | match_cnt | 32'(drop_cnt)), 0);
            stalled = 1'b0;
        end else begin
            chk("pkt_cnt", longint'(pkt_cnt), m_pkt);
            chk("drop_cnt", longint'(drop_cnt), m_drop);
            if (stalled) begin
                chk("stall_valid", longint'(rpt_valid), 1);
                chk("stall_hold", longint'({rpt_id, rpt_last}), longint'(held));
            end
            if (rpt_valid) begin
                if (exp_q.size() == 0) chk("spurious_record", longint'(rpt_id), -1);
                else if (rpt_ready) begin
                    chk("rec_id", longint'(rpt_id), longint'(exp_q[0].id));
                    chk("rec_last", longint'(rpt_last), longint'(exp_q[0].last));
                    log_q.push_back('{id: rpt_id, last: rpt_last});
                    void'(exp_q.pop_front());
                end
            end
            stalled = rpt_valid && !rpt_ready;
            held = {rpt_id, rpt_last};
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        log_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_ids[8];
        bit exp_last[8];
        exp_ids  = '{1, 5, 9, 13, 0, 2, 4, 6};
        exp_last = '{0, 0, 0, 1, 0, 0, 0, 1};

        // Bits 3 and 17, eod in the first cycle after release; latency check.
        do_reset();
        chk("t_reset_pkt", longint'(pkt_cnt), 0);
        rpt_ready = 1'b1;
        eng_match = 32'h0002_0008;
        eod = 1'b1;
        tick();
        eod = 1'b0;
        n = 1;
        while (!rpt_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, EL + 2);
        tick(6);
        chk("t036_nrec", log_q.size(), 2);
        chk("t036_id0", longint'(log_q[0].id), 3);
        chk("t036_last0", longint'(log_q[0].last), 0);
        chk("t036_id1", longint'(log_q[1].id), 17);
        chk("t036_last1", longint'(log_q[1].last), 1);
        chk("t036_match", longint'(match_cnt), 2);
        chk("t036_pkt", longint'(pkt_cnt), 1);

        // eod then sod one cycle later aborts the capture.
        do_reset();
        eng_match = 32'h0000_0020;
        eod = 1'b1;
        tick();
        eod = 1'b0;
        sod = 1'b1;
        tick();
        sod = 1'b0;
        tick(6);
        chk("t038_drop", longint'(drop_cnt), 1);
        chk("t038_pkt", longint'(pkt_cnt), 0);
        chk("t038_nrec", log_q.size(), 0);
        chk("t038_match", longint'(match_cnt), 0);

        // All-zero snapshot.
        do_reset();
        eng_match = '0;
        eod = 1'b1;
        tick();
        eod = 1'b0;
        tick(6);
        chk("t039_pkt", longint'(pkt_cnt), 1);
        chk("t039_match", longint'(match_cnt), 0);
        chk("t039_nrec", log_q.size(), 0);
        chk("t039_valid", longint'(rpt_valid), 0);

        // Three 4-match packets back to back with the consumer stalled.
        do_reset();
        rpt_ready = 1'b0;
        drop_at = snap_seq + 2;
        eng_match = 32'h0000_2222;
        eod = 1'b1;
        tick();
        eod = 1'b0;
        tick();
        eod = 1'b1;
        tick();
        eng_match = 32'h0000_0055;
        eod = 1'b0;
        tick();
        eod = 1'b1;
        tick();
        eng_match = 32'h0F00_0000;
        eod = 1'b0;
        tick(12);
        chk("t037_valid_held", longint'(rpt_valid), 1);
        chk("t037_match", longint'(match_cnt), 8);
        chk("t037_drop", longint'(drop_cnt), 1);
        chk("t037_pkt", longint'(pkt_cnt), 3);
        chk("t037_nrec_stalled", log_q.size(), 0);
        rpt_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        tick(2);
        drop_at = -1;
        chk("t037_nrec", log_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t037_id%0d", i), longint'(log_q[i].id), exp_ids[i]);
            chk($sformatf("t037_last%0d", i), longint'(log_q[i].last), longint'(exp_last[i]));
        end
        chk("t037_empty", longint'(rpt_valid), 0);

        // All 32 engines matching.
        do_reset();
        rpt_ready = 1'b1;
        eng_match = '1;
        eod = 1'b1;
        tick();
        eod = 1'b0;
        tick(45);
        chk("t040_nrec", log_q.size(), 32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t040_id%0d", i), longint'(log_q[i].id), i);
            chk($sformatf("t040_last%0d", i), longint'(log_q[i].last), (i == 31) ? 1 : 0);
        end
        chk("t040_match", longint'(match_cnt), 32);

        // Reset pulsed mid-scan with the FIFO half full.
        do_reset();
        rpt_ready = 1'b0;
        eng_match = 32'h0000_FF00;
        eod = 1'b1;
        tick();
        eod = 1'b0;
        tick(6);
        chk("t041_prefill", longint'(match_cnt), 4);
        #2;
        resetn = 1'b0;
        #1;
        chk("t041_valid_now", longint'(rpt_valid), 0);
        chk("t041_pkt_now", longint'(pkt_cnt), 0);
        chk("t041_match_now", longint'(match_cnt), 0);
        chk("t041_drop_now", longint'(drop_cnt), 0);
        tick(2);
        resetn = 1'b1;
        rpt_ready = 1'b1;
        log_q.delete();
        tick(20);
        chk("t041_nrec", log_q.size(), 0);
        chk("t041_valid", longint'(rpt_valid), 0);
        chk("t041_match", longint'(match_cnt), 0);
        chk("t041_exp_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
